// File: rtl/ahb_slave_responder_pkg.sv
// Shared AHB encodings and responder FSM states.
// Used by ahb_slave_responder and ahb_slv_be_gen.
package ahb_slave_responder_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_type;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_type;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ERR1   = 2'd2,
    ST_ERR2   = 2'd3
  } state_t;

  // Only NONSEQ and SEQ carry a real transfer.
  function automatic logic is_active(input htrans_type t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_slv_be_gen.sv
// Combinational byte-enable decoder: transfer size + address LSBs -> mem_be,
// flagging oversize or misaligned transfers as illegal.
module ahb_slv_be_gen
  import ahb_slave_responder_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] be,
  output logic       illegal
);

  always_comb begin
    be      = 4'b0000;
    illegal = 1'b0;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        if (addr_lo[0]) illegal = 1'b1;
        else            be      = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      HSIZE_WORD: begin
        if (addr_lo != 2'b00) illegal = 1'b1;
        else                  be      = 4'b1111;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_slave_responder.sv
// AHB slave endpoint bridging pipelined AHB transfers to a req/ack backend.
// Optional backend watchdog enabled by defining AHB_SLV_TIMEOUT_EN.
module ahb_slave_responder
  import ahb_slave_responder_pkg::*;
#(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int AHB_DATA_WIDTH = 32,
  parameter int MEM_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      hclk,
  input  logic                      hreset,
  input  logic                      hsel,
  input  logic [AHB_ADDR_WIDTH-1:0] haddr,
  input  htrans_type                htrans,
  input  logic                      hwrite,
  input  logic [2:0]                hsize,
  input  logic [AHB_DATA_WIDTH-1:0] hwdata,
  input  logic                      hready,
  output logic                      hreadyout,
  output hresp_type                 hresp,
  output logic [AHB_DATA_WIDTH-1:0] hrdata,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]                mem_be,
  output logic [AHB_DATA_WIDTH-1:0] mem_wdata,
  input  logic [AHB_DATA_WIDTH-1:0] mem_rdata,
  input  logic                      mem_ack,
  input  logic                      mem_err,
  output state_t                    dbg_state,
  output logic [AHB_ADDR_WIDTH-1:0] dbg_addr
);

  // Handshake: mem_req rises in the data phase and holds with stable
  // mem_we/mem_addr/mem_be until the cycle mem_ack is seen high; mem_err and
  // mem_rdata are only meaningful in that mem_ack cycle.

  state_t                    state_q, state_d;
  logic [AHB_ADDR_WIDTH-1:0] addr_q;
  logic                      write_q;
  logic [3:0]                be_q;

  logic       capture_req;
  logic       capture_en;
  logic       accept;
  logic [3:0] cap_be;
  logic       cap_illegal;
  logic       timeout_hit;

  // Decode on the live address phase; the decoded enables are what the
  // data phase needs, so they are registered instead of the raw size.
  ahb_slv_be_gen u_be_gen (
    .size    (hsize),
    .addr_lo (haddr[1:0]),
    .be      (cap_be),
    .illegal (cap_illegal)
  );

  assign capture_req = hsel && hready && is_active(htrans);

  always_comb begin
    state_d    = state_q;
    capture_en = 1'b0;
    accept     = 1'b0;
    hreadyout  = 1'b1;
    hresp      = HRESP_OKAY;
    hrdata     = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_be     = 4'b0000;
    case (state_q)
      ST_IDLE: begin
        capture_en = 1'b1;
      end
      ST_ACCESS: begin
        mem_req = 1'b1;
        mem_we  = write_q;
        mem_be  = be_q;
        if (!mem_ack) begin
          hreadyout = 1'b0;
          if (timeout_hit) state_d = ST_ERR1;
        end else if (mem_err) begin
          hreadyout = 1'b0;
          state_d   = ST_ERR1;
        end else begin
          hrdata     = write_q ? '0 : mem_rdata;
          capture_en = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
        state_d   = ST_ERR2;
      end
      ST_ERR2: begin
        hresp      = HRESP_ERROR;
        capture_en = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (capture_en && capture_req) begin
      accept  = 1'b1;
      state_d = cap_illegal ? ST_ERR1 : ST_ACCESS;
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      be_q    <= 4'b0000;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= haddr;
        write_q <= hwrite;
        be_q    <= cap_be;
      end
    end
  end

`ifdef AHB_SLV_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] tmr_q;

  // Fires on the last permitted wait cycle, so the FSM leaves ACCESS after
  // exactly TIMEOUT_CYCLES unacknowledged cycles.
  assign timeout_hit = (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset)                             tmr_q <= '0;
    else if (accept)                        tmr_q <= '0;
    else if (state_q == ST_ACCESS && !mem_ack) tmr_q <= tmr_q + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign mem_addr  = {addr_q[MEM_ADDR_WIDTH-1:2], 2'b00};
  assign mem_wdata = hwdata;
  assign dbg_state = state_q;
  assign dbg_addr  = addr_q;

endmodule

// File: tb/tb_ahb_slave_responder.sv
// Directed bench for ahb_slave_responder with backend/error scoreboards.
// Build with AHB_SLV_TIMEOUT_EN to exercise the watchdog path.
module tb_ahb_slave_responder;
  import ahb_slave_responder_pkg::*;

  localparam int MW = 49;  // {we, addr[11:0], be[3:0], data[31:0]}

  logic        hclk;
  logic        hreset;
  logic        hsel;
  logic [31:0] haddr;
  htrans_type  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  hresp_type   hresp;
  logic [31:0] hrdata;
  logic        mem_req;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        mem_err;
  state_t      dbg_state;
  logic [31:0] dbg_addr;

  int checks = 0;
  int errors = 0;

  logic [MW-1:0] exp_mem_q[$];
  logic [0:0]    exp_err_q[$];

  // Single-slave bus: bus-level hready is this slave's hreadyout.
  assign hready = hreadyout;

  ahb_slave_responder dut (
    .hclk      (hclk),
    .hreset    (hreset),
    .hsel      (hsel),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hwdata    (hwdata),
    .hready    (hready),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .hrdata    (hrdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .mem_err   (mem_err),
    .dbg_state (dbg_state),
    .dbg_addr  (dbg_addr)
  );

  // ---------------- clock / reset ----------------
  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [MW-1:0] rec(input logic we, input logic [11:0] a,
                                        input logic [3:0] be, input logic [31:0] d);
    return {we, a, be, d};
  endfunction

  task automatic bus_idle();
    hsel   = 1'b0;
    htrans = HTRANS_IDLE;
    haddr  = '0;
    hwrite = 1'b0;
    hsize  = HSIZE_WORD;
  endtask

  task automatic addr_phase(input logic we, input logic [31:0] a, input logic [2:0] sz,
                            input htrans_type tr);
    hsel   = 1'b1;
    htrans = tr;
    haddr  = a;
    hwrite = we;
    hsize  = sz;
  endtask

  // One transfer: address phase, then data phase with mem_ack pulsed at
  // data-phase cycle ack_delay (negative = never). Counts hreadyout-low cycles.
  task automatic do_xfer(input string name, input logic we, input logic [31:0] a,
                         input logic [2:0] sz, input logic [31:0] wdata,
                         input int ack_delay, input logic [31:0] rdata,
                         input logic err, input int exp_waits);
    int waits;
    int c;
    logic done;
    addr_phase(we, a, sz, HTRANS_NONSEQ);
    @(posedge hclk); #1;
    bus_idle();
    hwdata = wdata;
    waits = 0;
    c = 0;
    done = 1'b0;
    while (!done && c < 200) begin
      mem_ack   = (c == ack_delay);
      mem_err   = err && (c == ack_delay);
      mem_rdata = (c == ack_delay) ? rdata : 32'h0;
      @(negedge hclk);
      if (hreadyout) done = 1'b1;
      else           waits++;
      @(posedge hclk); #1;
      c++;
    end
    mem_ack   = 1'b0;
    mem_err   = 1'b0;
    mem_rdata = 32'h0;
    check({name, "_done"}, 64'(done), 64'd1);
    check({name, "_waits"}, 64'(waits), 64'(exp_waits));
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge hclk) begin
    if (!hreset) begin
      if (mem_req && mem_ack) begin
        if (exp_mem_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_unexpected: got we=%0b addr=0x%0h be=%b, none expected", mem_we, mem_addr, mem_be);
        end else begin
          check("mem_xfer", 64'(rec(mem_we, mem_addr, mem_be, mem_we ? mem_wdata : hrdata)),
                64'(exp_mem_q.pop_front()));
        end
      end else begin
        check("hrdata_idle_zero", 64'(hrdata), 64'd0);
      end
      if (hresp == HRESP_ERROR) begin
        if (exp_err_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL err_unexpected: got ERROR with hreadyout=%0b, none expected", hreadyout);
        end else begin
          check("err_hreadyout", 64'(hreadyout), 64'(exp_err_q.pop_front()));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    hreset    = 1'b1;
    hwdata    = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    mem_err   = 1'b0;
    bus_idle();
    #2;
    check("rst_hreadyout", 64'(hreadyout), 64'd1);
    check("rst_hresp",     64'(hresp),     64'(HRESP_OKAY));
    check("rst_hrdata",    64'(hrdata),    64'd0);
    check("rst_mem_req",   64'(mem_req),   64'd0);
    check("rst_mem_we",    64'(mem_we),    64'd0);
    check("rst_mem_be",    64'(mem_be),    64'd0);
    check("rst_mem_addr",  64'(mem_addr),  64'd0);
    check("rst_state",     64'(dbg_state), 64'(ST_IDLE));
    @(posedge hclk); #1;
    @(posedge hclk); #1;
    hreset = 1'b0;
    @(posedge hclk); #1;

    // Word write, same-cycle ack.
    exp_mem_q.push_back(rec(1'b1, 12'h104, 4'b1111, 32'hDEADBEEF));
    do_xfer("wr_word", 1'b1, 32'h0000_0104, HSIZE_WORD, 32'hDEADBEEF, 0, 32'h0, 1'b0, 0);

    // Byte read at 0x103, ack after 3 waits.
    exp_mem_q.push_back(rec(1'b0, 12'h100, 4'b1000, 32'hAA000000));
    do_xfer("rd_byte", 1'b0, 32'h0000_0103, HSIZE_BYTE, 32'h0, 3, 32'hAA000000, 1'b0, 3);

    // More byte-enable patterns.
    exp_mem_q.push_back(rec(1'b1, 12'h040, 4'b1100, 32'h1234_5678));
    do_xfer("wr_half_hi", 1'b1, 32'h0000_0042, HSIZE_HALF, 32'h1234_5678, 1, 32'h0, 1'b0, 1);
    exp_mem_q.push_back(rec(1'b1, 12'hFFC, 4'b0010, 32'h0000_5A00));
    do_xfer("wr_byte1", 1'b1, 32'h1000_0FFD, HSIZE_BYTE, 32'h0000_5A00, 0, 32'h0, 1'b0, 0);
    exp_mem_q.push_back(rec(1'b0, 12'h080, 4'b0011, 32'h0000_BEEF));
    do_xfer("rd_half_lo", 1'b0, 32'h0000_0080, HSIZE_HALF, 32'h0, 2, 32'h0000_BEEF, 1'b0, 2);

    // Back-to-back word reads with zero-wait ack.
    exp_mem_q.push_back(rec(1'b0, 12'h000, 4'b1111, 32'h1111_0000));
    exp_mem_q.push_back(rec(1'b0, 12'h004, 4'b1111, 32'h2222_0004));
    exp_mem_q.push_back(rec(1'b0, 12'h008, 4'b1111, 32'h3333_0008));
    addr_phase(1'b0, 32'h0, HSIZE_WORD, HTRANS_NONSEQ);
    @(posedge hclk); #1;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) addr_phase(1'b0, 32'(4 * (i + 1)), HSIZE_WORD, HTRANS_SEQ);
      else       bus_idle();
      mem_ack   = 1'b1;
      mem_rdata = (i == 0) ? 32'h1111_0000 : (i == 1) ? 32'h2222_0004 : 32'h3333_0008;
      @(negedge hclk);
      check("b2b_req",   64'(mem_req),   64'd1);
      check("b2b_ready", 64'(hreadyout), 64'd1);
      check("b2b_addr",  64'(mem_addr),  64'(4 * i));
      @(posedge hclk); #1;
    end
    mem_ack   = 1'b0;
    mem_rdata = '0;
    check("b2b_back_idle", 64'(dbg_state), 64'(ST_IDLE));

    // Illegal transfers: no backend access, two-cycle ERROR.
    exp_err_q.push_back(1'b0);
    exp_err_q.push_back(1'b1);
    do_xfer("ill_half", 1'b0, 32'h0000_0001, HSIZE_HALF, 32'h0, -1, 32'h0, 1'b0, 1);
    exp_err_q.push_back(1'b0);
    exp_err_q.push_back(1'b1);
    do_xfer("ill_size", 1'b1, 32'h0000_0010, 3'd3, 32'hCAFE_0000, -1, 32'h0, 1'b0, 1);
    exp_err_q.push_back(1'b0);
    exp_err_q.push_back(1'b1);
    do_xfer("ill_word", 1'b0, 32'h0000_0022, HSIZE_WORD, 32'h0, -1, 32'h0, 1'b0, 1);

    // Backend error on write.
    exp_mem_q.push_back(rec(1'b1, 12'h200, 4'b1111, 32'h0BAD_F00D));
    exp_err_q.push_back(1'b0);
    exp_err_q.push_back(1'b1);
    do_xfer("wr_err", 1'b1, 32'h0000_0200, HSIZE_WORD, 32'h0BAD_F00D, 1, 32'h0, 1'b1, 3);

    // Backend error, then reset asserted during ERR1.
    exp_mem_q.push_back(rec(1'b1, 12'h208, 4'b1111, 32'h5555_AAAA));
    addr_phase(1'b1, 32'h0000_0208, HSIZE_WORD, HTRANS_NONSEQ);
    @(posedge hclk); #1;
    bus_idle();
    hwdata  = 32'h5555_AAAA;
    mem_ack = 1'b1;
    mem_err = 1'b1;
    @(posedge hclk); #1;
    mem_ack = 1'b0;
    mem_err = 1'b0;
    exp_err_q.push_back(1'b0);
    @(negedge hclk);
    #1 hreset = 1'b1;
    #1;
    check("rst_mid_state",     64'(dbg_state), 64'(ST_IDLE));
    check("rst_mid_hreadyout", 64'(hreadyout), 64'd1);
    check("rst_mid_hresp",     64'(hresp),     64'(HRESP_OKAY));
    check("rst_mid_mem_req",   64'(mem_req),   64'd0);
    check("rst_mid_addr",      64'(dbg_addr),  64'd0);
    @(posedge hclk); #1;
    hreset = 1'b0;
    @(posedge hclk); #1;

    // Withheld ack.
`ifdef AHB_SLV_TIMEOUT_EN
    exp_err_q.push_back(1'b0);
    exp_err_q.push_back(1'b1);
    do_xfer("timeout", 1'b0, 32'h0000_0300, HSIZE_WORD, 32'h0, -1, 32'h0, 1'b0, 17);
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    @(negedge hclk);
    check("late_ack_no_req", 64'(mem_req), 64'd0);
    @(posedge hclk); #1;
    mem_ack   = 1'b0;
    mem_rdata = '0;
`else
    begin
      logic still_waiting;
      still_waiting = 1'b1;
      addr_phase(1'b0, 32'h0000_0300, HSIZE_WORD, HTRANS_NONSEQ);
      @(posedge hclk); #1;
      bus_idle();
      for (int i = 0; i < 100; i++) begin
        @(negedge hclk);
        if (hreadyout !== 1'b0 || mem_req !== 1'b1) still_waiting = 1'b0;
        @(posedge hclk); #1;
      end
      check("no_timeout_wait", 64'(still_waiting), 64'd1);
      check("no_timeout_state", 64'(dbg_state), 64'(ST_ACCESS));
      exp_mem_q.push_back(rec(1'b0, 12'h300, 4'b1111, 32'h7777_3000));
      mem_ack   = 1'b1;
      mem_rdata = 32'h7777_3000;
      @(negedge hclk);
      check("no_timeout_done", 64'(hreadyout), 64'd1);
      @(posedge hclk); #1;
      mem_ack   = 1'b0;
      mem_rdata = '0;
    end
`endif

    repeat (3) @(posedge hclk);
    #1;
    check("mem_q_drained", 64'(exp_mem_q.size()), 64'd0);
    check("err_q_drained", 64'(exp_err_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
